// File: rtl/alu_sequencer.sv
// Microcoded control sequencer for a register-file/ALU datapath: fetch (T0-T2),
// then class-dependent execute steps (T3-T6) with one-hot register strobes.
module alu_sequencer #(
    parameter int              NREG    = 16,
    parameter int              OPW     = 4,
    parameter logic [OPW-1:0]  ALU_ADD = OPW'(0),
    parameter logic [OPW-1:0]  ALU_AND = OPW'(1),
    parameter logic [OPW-1:0]  ALU_OR  = OPW'(2),
    parameter logic [OPW-1:0]  ALU_MUL = OPW'(12),
    parameter logic [OPW-1:0]  ALU_DIV = OPW'(13)
) (
    input  logic              clock,
    input  logic              clear_n,
    input  logic              start,
    input  logic              mem_rdy,
    input  logic [31:0]       ir,
    output logic              PCout,
    output logic              PCin,
    output logic              IncPC,
    output logic              MARin,
    output logic              Read,
    output logic              MDRin,
    output logic              MDRout,
    output logic              IRin,
    output logic              Yin,
    output logic              Cout,
    output logic              Zlowin,
    output logic              Zhighin,
    output logic              Zlowout,
    output logic              Zhighout,
    output logic              HIin,
    output logic              LOin,
    output logic [NREG-1:0]   Rin,
    output logic [NREG-1:0]   Rout,
    output logic [OPW-1:0]    ALUop,
    output logic              busy,
    output logic              done,
    output logic              illegal
);

    typedef enum logic [2:0] {IDLE, T0, T1, T2, T3, T4, T5, T6} state_t;

    state_t      state_q, state_d;
    logic [4:0]  opcode_q, opcode_d;
    logic [3:0]  ra_q, ra_d, rb_q, rb_d, rc_q, rc_d;
    logic        illegal_q, illegal_d;

    logic           ir_legal;
    logic           cls_unary, cls_wide, cls_imm, cls_rtype;
    logic [OPW-1:0] alu_sel;
    logic           unused_ok;

    assign unused_ok = &{1'b0, ir[14:0]};

    function automatic logic [NREG-1:0] onehot(input logic [3:0] idx);
        logic [NREG-1:0] v;
        v = '0;
        for (int i = 0; i < NREG; i++) begin
            v[i] = (idx == 4'(i));
        end
        return v;
    endfunction

    // rc is only an operand for R-type; ra/rb are checked for every class.
    always_comb begin
        ir_legal = (ir[31:27] <= 5'h12)
                && ({1'b0, ir[26:23]} < 5'(NREG))
                && ({1'b0, ir[22:19]} < 5'(NREG))
                && ((ir[31:27] > 5'h0B) || ({1'b0, ir[18:15]} < 5'(NREG)));
    end

    always_comb begin
        cls_rtype = (opcode_q <= 5'h0B);
        cls_imm   = (opcode_q >= 5'h0C) && (opcode_q <= 5'h0E);
        cls_wide  = (opcode_q == 5'h0F) || (opcode_q == 5'h10);
        cls_unary = (opcode_q == 5'h11) || (opcode_q == 5'h12);
        case (opcode_q)
            5'h0C:   alu_sel = ALU_ADD;
            5'h0D:   alu_sel = ALU_AND;
            5'h0E:   alu_sel = ALU_OR;
            5'h0F:   alu_sel = ALU_MUL;
            5'h10:   alu_sel = ALU_DIV;
            default: alu_sel = OPW'(opcode_q);
        endcase
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_q   <= IDLE;
            opcode_q  <= '0;
            ra_q      <= '0;
            rb_q      <= '0;
            rc_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            ra_q      <= ra_d;
            rb_q      <= rb_d;
            rc_q      <= rc_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        opcode_d  = opcode_q;
        ra_d      = ra_q;
        rb_d      = rb_q;
        rc_d      = rc_q;
        illegal_d = illegal_q;
        PCout = 1'b0; PCin = 1'b0; IncPC = 1'b0; MARin = 1'b0;
        Read = 1'b0; MDRin = 1'b0; MDRout = 1'b0; IRin = 1'b0;
        Yin = 1'b0; Cout = 1'b0; Zlowin = 1'b0; Zhighin = 1'b0;
        Zlowout = 1'b0; Zhighout = 1'b0; HIin = 1'b0; LOin = 1'b0;
        Rin   = '0;
        Rout  = '0;
        ALUop = '0;
        done  = 1'b0;
        busy  = (state_q != IDLE);
        illegal = illegal_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = T0;
                    illegal_d = 1'b0;
                end
            end
            T0: begin
                PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zlowin = 1'b1;
                state_d = T1;
            end
            T1: begin
                Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
                if (mem_rdy) state_d = T2;
            end
            T2: begin
                MDRout = 1'b1; IRin = 1'b1;
                opcode_d = ir[31:27];
                ra_d     = ir[26:23];
                rb_d     = ir[22:19];
                rc_d     = ir[18:15];
                if (ir_legal) begin
                    state_d = T3;
                end else begin
                    state_d   = IDLE;
                    illegal_d = 1'b1;
                end
            end
            T3: begin
                state_d = T4;
                if (cls_unary) begin
                    Rout = onehot(rb_q); ALUop = alu_sel; Zlowin = 1'b1;
                end else if (cls_wide) begin
                    Rout = onehot(ra_q); Yin = 1'b1;
                end else begin
                    Rout = onehot(rb_q); Yin = 1'b1;
                end
            end
            T4: begin
                state_d = cls_unary ? IDLE : T5;
                if (cls_unary) begin
                    Zlowout = 1'b1; Rin = onehot(ra_q); done = 1'b1;
                end else if (cls_wide) begin
                    Rout = onehot(rb_q); ALUop = alu_sel;
                    Zlowin = 1'b1; Zhighin = 1'b1;
                end else begin
                    if (cls_rtype) Rout = onehot(rc_q);
                    Cout   = cls_imm;
                    ALUop  = alu_sel;
                    Zlowin = 1'b1;
                end
            end
            T5: begin
                Zlowout = 1'b1;
                if (cls_wide) begin
                    LOin = 1'b1; state_d = T6;
                end else begin
                    Rin = onehot(ra_q); done = 1'b1; state_d = IDLE;
                end
            end
            T6: begin
                Zhighout = 1'b1; HIin = 1'b1; done = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
